operand_fetch_writeback: RTL and testbench

//  Initiator side of the 16x16 register bank: sequences one instruction at a time.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/operand_fetch_writeback.sv | 115 +++++++++++
 tb/tb_operand_fetch_writeback.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the operand fetch/writeback controller state encoding.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int OP_WIDTH   = 4;

  // IDLE..WAIT_RES keep their original 2-bit codes; WRITEBACK needs the third bit.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RES  = 3'd3,
    WRITEBACK = 3'd4
  } ofw_state_e;

endpackage

// File: rtl/operand_fetch_writeback.sv
// Register-bank initiator: fetches two operands, hands them to execute, writes the result back.
// One instruction in flight at a time, so the bank never needs forwarding.
module operand_fetch_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int OP_WIDTH   = cpu_pkg::OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OP_WIDTH-1:0]   instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic                  instr_wb,
  output logic [ADDR_WIDTH-1:0] rf_address_a,
  output logic [ADDR_WIDTH-1:0] rf_address_b,
  input  logic [DATA_WIDTH-1:0] rf_data_a,
  input  logic [DATA_WIDTH-1:0] rf_data_b,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_address_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  output logic                  exe_valid,
  input  logic                  exe_ready,
  output logic [OP_WIDTH-1:0]   exe_op,
  output logic [DATA_WIDTH-1:0] exe_operand_a,
  output logic [DATA_WIDTH-1:0] exe_operand_b,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic [15:0]           retire_count
);

  ofw_state_e state_q, state_d;

  logic [OP_WIDTH-1:0]   op_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q, wa_q;
  logic                  wb_q;
  logic [DATA_WIDTH-1:0] opa_q, opb_q, wd_q;
  logic [15:0]           retire_count_q;
  logic                  accept, fetch_done, res_take, retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (instr_valid) state_d = FETCH;
      FETCH:     state_d = ISSUE;
      ISSUE:     if (exe_ready) state_d = WAIT_RES;
      WAIT_RES:  if (res_valid) state_d = wb_q ? WRITEBACK : IDLE;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Handshake strobes are qualified by state, so stray inputs in other states are ignored.
  assign accept     = (state_q == IDLE) && instr_valid;
  assign fetch_done = (state_q == FETCH);
  assign res_take   = (state_q == WAIT_RES) && res_valid;
  assign retire     = (res_take && !wb_q) || (state_q == WRITEBACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      wb_q           <= 1'b0;
      opa_q          <= '0;
      opb_q          <= '0;
      wa_q           <= '0;
      wd_q           <= '0;
      retire_count_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        rd_q  <= instr_rd;
        wb_q  <= instr_wb;
      end
      if (fetch_done) begin
        opa_q <= rf_data_a;
        opb_q <= rf_data_b;
      end
      if (res_take) begin
        wd_q <= res_data;
        wa_q <= rd_q;
      end
      if (retire) retire_count_q <= retire_count_q + 16'd1;
    end
  end

  assign instr_ready     = (state_q == IDLE);
  assign exe_valid       = (state_q == ISSUE);
  assign res_ready       = (state_q == WAIT_RES);
  assign rf_write_enable = (state_q == WRITEBACK);

  assign rf_address_a  = rs1_q;
  assign rf_address_b  = rs2_q;
  assign rf_address_w  = wa_q;
  assign rf_data_w     = wd_q;
  assign exe_op        = op_q;
  assign exe_operand_a = opa_q;
  assign exe_operand_b = opb_q;
  assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_operand_fetch_writeback.sv
// Directed + randomized bench: behavioural register bank, execute responder and a
// per-instruction reference model of operands, write-back and retire count.
module tb_operand_fetch_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready, instr_wb;
  logic [3:0]  instr_op, instr_rs1, instr_rs2, instr_rd;
  logic [3:0]  rf_address_a, rf_address_b, rf_address_w;
  logic [15:0] rf_data_a, rf_data_b, rf_data_w;
  logic        rf_write_enable;
  logic        exe_valid, exe_ready;
  logic [3:0]  exe_op;
  logic [15:0] exe_operand_a, exe_operand_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [15:0] retire_count;

  always #5 clk = ~clk;

  operand_fetch_writeback dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd), .instr_wb(instr_wb),
    .rf_address_a(rf_address_a), .rf_address_b(rf_address_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .rf_write_enable(rf_write_enable), .rf_address_w(rf_address_w), .rf_data_w(rf_data_w),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_op(exe_op),
    .exe_operand_a(exe_operand_a), .exe_operand_b(exe_operand_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .retire_count(retire_count)
  );

  // The bank itself: combinational reads, posedge writes, untouched by reset.
  logic [15:0] bank [16];
  logic        tb_we;
  logic [3:0]  tb_wa;
  logic [15:0] tb_wd;
  assign rf_data_a = bank[rf_address_a];
  assign rf_data_b = bank[rf_address_b];
  always @(posedge clk) begin
    if (rf_write_enable) bank[rf_address_w] <= rf_data_w;
    else if (tb_we)      bank[tb_wa] <= tb_wd;
  end

  logic [15:0] ref_rf [16];
  logic [15:0] exp_retire;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op[1:0])
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a ^ b;
      default: return a & b;
    endcase
  endfunction

  task automatic load_reg(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, bank[i], ref_rf[i]);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, " exe_valid"}, exe_valid, 1'b0);
    chk({tag, " wr_en"}, rf_write_enable, 1'b0);
    chk({tag, " res_ready"}, res_ready, 1'b0);
    chk({tag, " instr_ready"}, instr_ready, 1'b1);
    chk({tag, " retire"}, retire_count, 16'h0);
    chk({tag, " opa"}, exe_operand_a, 16'h0);
    chk({tag, " wdata"}, rf_data_w, 16'h0);
    exp_retire = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    check_bank({tag, " bank"});
  endtask

  // Runs one instruction end to end; called just after a negedge with the controller in IDLE.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic wb, input int exe_dly, input int res_dly,
                           input bit pulse_res, input bit rst_wait, input bit rst_wb);
    logic [15:0] a, b, r;
    a = ref_rf[rs1];
    b = ref_rf[rs2];
    r = alu(op, a, b);
    chk("accept ready", instr_ready, 1'b1);
    instr_valid = 1'b1; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd; instr_wb = wb;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op = 4'($urandom); instr_rs1 = 4'($urandom); instr_rs2 = 4'($urandom);
    instr_rd = 4'($urandom); instr_wb = 1'($urandom);
    chk("fetch addr_a", rf_address_a, rs1);
    chk("fetch addr_b", rf_address_b, rs2);
    chk("fetch exe_valid", exe_valid, 1'b0);
    chk("fetch instr_ready", instr_ready, 1'b0);
    @(negedge clk);
    chk("issue exe_valid", exe_valid, 1'b1);
    chk("issue op", exe_op, op);
    chk("issue opa", exe_operand_a, a);
    chk("issue opb", exe_operand_b, b);
    for (int k = 0; k < exe_dly; k++) begin
      if (pulse_res && k == 0) begin res_valid = 1'b1; res_data = 16'hDEAD; end
      @(negedge clk);
      res_valid = 1'b0;
      chk("stall exe_valid", exe_valid, 1'b1);
      chk("stall opa", exe_operand_a, a);
      chk("stall opb", exe_operand_b, b);
      chk("stall op", exe_op, op);
      chk("stall wr_en", rf_write_enable, 1'b0);
      chk("stall res_ready", res_ready, 1'b0);
    end
    exe_ready = 1'b1;
    @(negedge clk);
    exe_ready = 1'b0;
    chk("wait exe_valid", exe_valid, 1'b0);
    chk("wait res_ready", res_ready, 1'b1);
    if (rst_wait) begin do_reset("rst_wait"); return; end
    for (int k = 0; k < res_dly; k++) begin
      @(negedge clk);
      chk("wait res_ready hold", res_ready, 1'b1);
      chk("wait wr_en", rf_write_enable, 1'b0);
    end
    res_valid = 1'b1; res_data = r;
    @(negedge clk);
    res_valid = 1'b0; res_data = 16'($urandom);
    if (wb) begin
      chk("wb wr_en", rf_write_enable, 1'b1);
      chk("wb addr", rf_address_w, rd);
      chk("wb data", rf_data_w, r);
      chk("wb retire pre", retire_count, exp_retire);
      if (rst_wb) begin do_reset("rst_wb"); return; end
      @(negedge clk);
      ref_rf[rd] = r;
    end
    exp_retire = exp_retire + 16'd1;
    chk("done wr_en", rf_write_enable, 1'b0);
    chk("done instr_ready", instr_ready, 1'b1);
    chk("done retire", retire_count, exp_retire);
    chk("done bank rd", bank[rd], ref_rf[rd]);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0; instr_op = '0; instr_rs1 = '0; instr_rs2 = '0; instr_rd = '0; instr_wb = 1'b0;
    exe_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    exp_retire = 16'h0;
    #1;
    chk("reset instr_ready", instr_ready, 1'b1);
    chk("reset exe_valid", exe_valid, 1'b0);
    chk("reset wr_en", rf_write_enable, 1'b0);
    chk("reset res_ready", res_ready, 1'b0);
    chk("reset retire", retire_count, 16'h0);
    chk("reset addr_a", rf_address_a, 4'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) load_reg(4'(i), 16'($urandom));

    // R1+R2 -> R3
    load_reg(4'd1, 16'h0005);
    load_reg(4'd2, 16'h0003);
    run_instr(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("basic R3", bank[3], 16'h0008);
    chk("basic retire", retire_count, 16'h0001);

    // Execute stalls five cycles
    run_instr(4'd1, 4'd7, 4'd9, 4'd10, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
    // No write-back
    run_instr(4'd2, 4'd3, 4'd1, 4'd5, 1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    chk("nowb retire", retire_count, 16'h0003);

    // Back-to-back write then read of the same register
    load_reg(4'd5, 16'h1234);
    load_reg(4'd6, 16'h0000);
    run_instr(4'd0, 4'd5, 4'd6, 4'd4, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(4'd0, 4'd4, 4'd6, 4'd7, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("b2b R7", bank[7], 16'h1234);

    // Stray result during ISSUE, and all-zero register indices
    run_instr(4'd3, 4'd0, 4'd0, 4'd0, 1'b1, 2, 1, 1'b1, 1'b0, 1'b0);

    // Reset mid-instruction
    run_instr(4'd0, 4'd1, 4'd2, 4'd8, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(4'd0, 4'd1, 4'd2, 4'd9, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);
    run_instr(4'd0, 4'd1, 4'd2, 4'd9, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 1'b0);
    check_bank("random bank");

    // Preload the counter near the top rather than spending 65536 instructions getting there.
    dut.retire_count_q = 16'hFFFE;
    exp_retire = 16'hFFFE;
    run_instr(4'd0, 4'd2, 4'd3, 4'd11, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(4'd1, 4'd11, 4'd2, 4'd12, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrap retire", retire_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
